aes_tcdm_responder: RTL and testbench
=====================================

AES_TCDM_RESPONDER -- requirements
Module: aes_tcdm_responder

Interface
REQ-001 Parameter MP, default 2, number of TCDM slave ports served, one per accelerator TCDM master port.
REQ-002 Parameter DEPTH, default 1024, number of 32-bit words in the bank; power of two, at least 2.
REQ-003 Parameter STALL_EN, default 0, enables the stall_i grant-suppression input when 1; stall_i is ignored when 0.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 stall_i  input  1  when high (and STALL_EN=1), no grant is issued this cycle.
REQ-007 tcdm_req_i  input  MP  per-port request.
REQ-008 tcdm_gnt_o  output  MP  per-port grant, combinational from the current cycle's req and arbiter state.
REQ-009 tcdm_add_i  input  MPx32  per-port byte address.
REQ-010 tcdm_wen_i  input  MP  per-port direction: 1 = read, 0 = write.
REQ-011 tcdm_be_i  input  MPx4  per-port byte enables, used for writes only.
REQ-012 tcdm_data_i  input  MPx32  per-port write data.
REQ-013 tcdm_r_data_o  output  MPx32  per-port read data.
REQ-014 tcdm_r_valid_o  output  MP  per-port read-data valid pulse.

Function
REQ-015 At most one port shall be granted per cycle; a transaction completes in the cycle where req and gnt are both high.
REQ-016 Arbitration shall be round-robin: priority starts at pointer p and the first requesting port at or after p, modulo MP, is granted.
REQ-017 After a grant to port k, p shall become (k+1) mod MP; with no grant, p shall hold.
REQ-018 The word index shall be add[2 +: log2(DEPTH)]; add[1:0] and higher bits shall be ignored, so out-of-range addresses wrap modulo DEPTH.
REQ-019 A granted write shall update only the bytes whose be bit is 1, visible from the next cycle; be=0000 leaves the word unchanged.
REQ-020 A granted read shall drive r_valid high on the same port for exactly one cycle, the cycle after the grant, with r_data equal to the word content at grant time.
REQ-021 A granted write shall not assert r_valid.
REQ-022 A read granted the cycle after a write to the same word shall return the newly written data.
REQ-023 r_data of a port shall hold its last value while that port's r_valid is low.
REQ-024 Back-to-back reads from one port shall be possible at one per cycle when it is the only requester.
REQ-025 With stall_i high (STALL_EN=1), all gnt shall be 0, p shall hold, and no memory access shall occur; a read response already in flight shall still be delivered.
REQ-026 A port deasserting req without a grant is legal; no state shall change for that port.

Reset
REQ-027 While rst_i is high at a clock edge: p=0, all r_valid=0, all r_data=0, all gnt=0 (gnt is forced low during reset).
REQ-028 A read granted in the cycle before reset asserts shall not produce r_valid after reset.
REQ-029 Memory contents shall not be cleared by reset.

Structure
REQ-030 Shared TCDM constants (data width 32, byte-enable width 4, wen read encoding 1) shall reside in aes_package.
REQ-031 Arbitration shall be a sub-module aes_tcdm_rr_arb with inputs req[MP], stall and rst, and outputs one-hot gnt[MP] and the granted index.
REQ-032 Storage shall be a single behavioural array of DEPTH x 32 with per-byte write enable.

Verification
REQ-033 Single port: write 0xDEADBEEF to address 0x10 with be=1111, then read 0x10 -> r_valid one cycle after gnt, r_data=0xDEADBEEF.
REQ-034 Partial write: word at 0x20 holds 0x11223344; write 0xAABBCCDD with be=0101 -> read returns 0x11BB33DD.
REQ-035 MP=2, both ports request continuously for 6 cycles starting from p=0 -> grants alternate 0,1,0,1,0,1.
REQ-036 Wrap: with DEPTH=1024, write 0x5 to address 0x1000, read address 0x0 -> 0x00000005.
REQ-037 Stall: STALL_EN=1, stall_i high for 3 cycles with port 1 requesting -> gnt stays 0 and p is unchanged; port 1 is granted in the first cycle after stall_i drops.
REQ-038 Reset mid-read: read granted at cycle N, rst_i high at cycle N+1 -> r_valid stays 0 and p=0 after reset.

Source files
------------

// File: rtl/aes_package.sv
// Shared TCDM interface constants and types for the AES accelerator memory side.
package aes_package;

    localparam int unsigned TCDM_DW  = 32;
    localparam int unsigned TCDM_BEW = TCDM_DW / 8;

    // Encoding of the TCDM wen line.
    typedef enum logic {
        TCDM_WRITE = 1'b0,
        TCDM_READ  = 1'b1
    } tcdm_dir_e;

    localparam logic TCDM_WEN_READ = TCDM_READ;

    typedef logic [TCDM_DW-1:0]  tcdm_data_t;
    typedef logic [TCDM_BEW-1:0] tcdm_be_t;

endpackage : aes_package

// File: rtl/aes_tcdm_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// priority pointer; the pointer moves past the winner and holds otherwise.
module aes_tcdm_rr_arb
    import aes_package::*;
#(
    parameter int unsigned MP = 2,
    parameter int unsigned IW = (MP > 1) ? $clog2(MP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [MP-1:0] req_i,
    input  logic          stall_i,
    output logic [MP-1:0] gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;
    logic          found;

    // Scan requesters starting at the pointer, wrapping modulo MP; reset and
    // stall suppress every grant.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        if (!rst_i && !stall_i) begin
            for (int unsigned i = 0; i < MP; i++) begin
                cand = {1'b0, ptr_q} + (IW+1)'(i);
                if (cand >= (IW+1)'(MP)) begin
                    cand = cand - (IW+1)'(MP);
                end
                if (!found && req_i[cand[IW-1:0]]) begin
                    found                 = 1'b1;
                    gnt_o[cand[IW-1:0]]   = 1'b1;
                    idx_o                 = cand[IW-1:0];
                end
            end
        end
    end

    // Next priority is the port just after the winner.
    always_comb begin
        ptr_d = (idx_o == IW'(MP - 1)) ? '0 : idx_o + 1'b1;
    end

    // Pointer register: cleared by reset, advanced only on a grant.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled before the edge.
        if (rst_i) begin
            ptr_q <= '0;
        end else if (|gnt_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule : aes_tcdm_rr_arb

// File: rtl/aes_tcdm_responder.sv
// Single-bank TCDM slave model shared by MP accelerator master ports:
// round-robin arbitration, byte-masked writes, one-cycle read latency.
module aes_tcdm_responder
    import aes_package::*;
#(
    parameter int unsigned MP       = 2,
    parameter int unsigned DEPTH    = 1024,
    parameter bit          STALL_EN = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        stall_i,
    input  logic [MP-1:0]               tcdm_req_i,
    output logic [MP-1:0]               tcdm_gnt_o,
    input  logic [MP-1:0][31:0]         tcdm_add_i,
    input  logic [MP-1:0]               tcdm_wen_i,
    input  logic [MP-1:0][TCDM_BEW-1:0] tcdm_be_i,
    input  logic [MP-1:0][TCDM_DW-1:0]  tcdm_data_i,
    output logic [MP-1:0][TCDM_DW-1:0]  tcdm_r_data_o,
    output logic [MP-1:0]               tcdm_r_valid_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = (MP > 1) ? $clog2(MP) : 1;

    logic          stall_eff;
    logic [IW-1:0] gnt_idx;
    logic [31:0]   sel_add;
    logic [AW-1:0] word_idx;
    logic          sel_read;
    logic          rd_en, wr_en;
    logic          unused_add;

    tcdm_data_t          mem_q [DEPTH];
    logic [MP-1:0]       r_valid_q;
    tcdm_data_t [MP-1:0] r_data_q;

    assign stall_eff = STALL_EN ? stall_i : 1'b0;

    aes_tcdm_rr_arb #(.MP(MP), .IW(IW)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (tcdm_req_i),
        .stall_i (stall_eff),
        .gnt_o   (tcdm_gnt_o),
        .idx_o   (gnt_idx)
    );

    // Word index ignores the byte offset and everything above the bank size,
    // so out-of-range addresses alias back into the bank.
    assign sel_add    = tcdm_add_i[gnt_idx];
    assign word_idx   = sel_add[2 +: AW];
    assign unused_add = ^{sel_add[31:2+AW], sel_add[1:0]};
    assign sel_read   = (tcdm_wen_i[gnt_idx] == TCDM_WEN_READ);
    assign rd_en      = (|tcdm_gnt_o) && sel_read;
    assign wr_en      = (|tcdm_gnt_o) && !sel_read;

    // Byte-masked write of the granted port into the bank.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately left out of reset so it
        // maps onto plain RAM; contents survive rst_i.
        if (wr_en) begin
            for (int unsigned b = 0; b < TCDM_BEW; b++) begin
                if (tcdm_be_i[gnt_idx][b]) begin
                    mem_q[word_idx][8*b +: 8] <= tcdm_data_i[gnt_idx][8*b +: 8];
                end
            end
        end
    end

    // Read response: capture the word at grant time and pulse valid next cycle;
    // data of idle ports holds its last value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= tcdm_gnt_o & ~(tcdm_wen_i ^ {MP{TCDM_WEN_READ}});
            if (rd_en) begin
                r_data_q[gnt_idx] <= mem_q[word_idx];
            end
        end
    end

    // A response pending when reset arrives is dropped, not delivered.
    assign tcdm_r_valid_o = r_valid_q & {MP{~rst_i}};
    assign tcdm_r_data_o  = r_data_q;

endmodule : aes_tcdm_responder

// File: tb/tb_aes_tcdm_responder.sv
// Directed self-checking bench for aes_tcdm_responder (MP=2, DEPTH=1024, STALL_EN=1).
module tb_aes_tcdm_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [1:0][31:0] add;
    logic [1:0]       wen;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata;
    logic [1:0][31:0] rdata;
    logic [1:0]       rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_tcdm_responder #(.MP(2), .DEPTH(1024), .STALL_EN(1'b1)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_be_i      (be),
        .tcdm_data_i    (wdata),
        .tcdm_r_data_o  (rdata),
        .tcdm_r_valid_o (rvalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        req   = '0;
        wen   = '0;
        add   = '0;
        be    = '0;
        wdata = '0;
    endtask

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
        req[p]   = r;
        wen[p]   = w;
        add[p]   = a;
        be[p]    = b;
        wdata[p] = d;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        idle_all();

        // Reset: grants forced low even with a request present.
        drive_port(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0);
        #1 check("rst_gnt", gnt, 32'h0);
        tick();
        tick();
        check("rst_rvalid", rvalid, 32'h0);
        check("rst_rdata0", rdata[0], 32'h0);
        check("rst_rdata1", rdata[1], 32'h0);
        check("rst_gnt_held", gnt, 32'h0);
        rst = 1'b0;
        idle_all();

        // Full write then immediate read of the same word.
        drive_port(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
        #1 check("wr_gnt", gnt, 32'h1);
        tick();
        check("wr_no_rvalid", rvalid, 32'h0);
        drive_port(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0);
        #1 check("rd_gnt", gnt, 32'h1);
        tick();
        check("rd_rvalid", rvalid, 32'h1);
        check("rd_data", rdata[0], 32'hDEADBEEF);
        idle_all();
        tick();
        check("rvalid_pulse", rvalid, 32'h0);
        check("rdata_hold", rdata[0], 32'hDEADBEEF);

        // Partial write with be=0101, read via port 1 with byte offset set.
        drive_port(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h11223344);
        tick();
        drive_port(0, 1'b1, 1'b0, 32'h20, 4'h5, 32'hAABBCCDD);
        tick();
        idle_all();
        drive_port(1, 1'b1, 1'b1, 32'h23, 4'h0, 32'h0);
        #1 check("p1_gnt", gnt, 32'h2);
        tick();
        check("p1_rvalid", rvalid, 32'h2);
        check("partial_data", rdata[1], 32'h11BB33DD);
        check("p0_untouched", rdata[0], 32'hDEADBEEF);

        // be=0000 write leaves the word intact.
        drive_port(1, 1'b1, 1'b0, 32'h20, 4'h0, 32'hFFFFFFFF);
        tick();
        check("be0_no_rvalid", rvalid, 32'h0);
        drive_port(1, 1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
        tick();
        check("be0_data", rdata[1], 32'h11BB33DD);
        idle_all();

        // Address wrap: 0x1000 aliases word 0; then back-to-back reads.
        drive_port(0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h5);
        tick();
        drive_port(0, 1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
        tick();
        check("wrap_data", rdata[0], 32'h5);
        drive_port(0, 1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
        #1 check("b2b_gnt1", gnt, 32'h1);
        tick();
        check("b2b_rvalid1", rvalid, 32'h1);
        check("b2b_data1", rdata[0], 32'hDEADBEEF);
        drive_port(0, 1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
        #1 check("b2b_gnt2", gnt, 32'h1);
        tick();
        check("b2b_rvalid2", rvalid, 32'h1);
        check("b2b_data2", rdata[0], 32'h11BB33DD);
        idle_all();

        // Reset arriving right after a read grant: response is dropped.
        drive_port(0, 1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
        #1 check("rstmid_gnt", gnt, 32'h1);
        tick();
        rst = 1'b1;
        idle_all();
        #1 check("rstmid_rvalid", rvalid, 32'h0);
        tick();
        check("rstmid_rvalid_after", rvalid, 32'h0);
        rst = 1'b0;

        // Both ports request continuously: pointer back at 0 gives 0,1,0,1,0,1.
        // Memory contents survived the reset.
        drive_port(0, 1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
        drive_port(1, 1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("alt_gnt%0d", i), gnt, (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check($sformatf("alt_rvalid%0d", i), rvalid, (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i % 2 == 0) check($sformatf("alt_data%0d", i), rdata[0], 32'hDEADBEEF);
            else            check($sformatf("alt_data%0d", i), rdata[1], 32'h11BB33DD);
        end
        idle_all();

        // Stall: grant port 0 (pointer -> 1), then stall 3 cycles with port 1
        // requesting; the pending read still completes.
        drive_port(0, 1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
        #1 check("pre_stall_gnt", gnt, 32'h1);
        tick();
        stall = 1'b1;
        idle_all();
        drive_port(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("stall_gnt%0d", i), gnt, 32'h0);
            if (i == 0) begin
                check("stall_inflight_rvalid", rvalid, 32'h1);
                check("stall_inflight_data", rdata[0], 32'h11BB33DD);
            end
            tick();
        end
        check("stall_no_rvalid", rvalid, 32'h0);
        stall = 1'b0;
        drive_port(0, 1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
        #1 check("stall_release_gnt", gnt, 32'h2);
        tick();
        drive_port(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1 check("post_stall_gnt", gnt, 32'h1);
        tick();
        check("post_stall_rvalid", rvalid, 32'h1);
        check("post_stall_data", rdata[0], 32'h12345678);
        idle_all();
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_aes_tcdm_responder
